// File: rtl/sipo_deserializer.sv
// sipo_deserializer
//   Serial-in, parallel-out word receiver. Collects WIDTH bits (one per clock
//   while sin_valid is high), MSB-first or LSB-first, and presents each
//   completed word in a single-entry output register with a valid/ready
//   handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   sin_valid  sin_bit is valid this cycle
//   sin_bit    serial data bit
//   dir        0 = MSB-first, 1 = LSB-first; latched on the first bit of a word
//   flush      synchronous discard of the partial word (wins over sin_valid)
//   dout       last completed word
//   dout_valid dout holds an unconsumed word
//   dout_ready consumer accepts dout this cycle
//   overrun    sticky: a completed word was dropped
//   clr_ovr    synchronous clear of overrun (a same-cycle overrun wins)
//   bit_cnt    bits collected in the current word
//   busy       bit_cnt != 0
module sipo_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin_valid,
  input  logic             sin_bit,
  input  logic             dir,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy
);

  typedef enum logic {EMPTY, FULL} slot_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  slot_t            slot_q, slot_d;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic             dir_q;
  logic             eff_dir;
  logic             accept;
  logic             complete;
  logic             slot_free;
  logic             load;
  logic             ovr_set;

  // The first bit of a word uses the live dir input; later bits use the
  // value latched alongside that first bit.
  assign eff_dir   = (bit_cnt == '0) ? dir : dir_q;
  assign shifted   = eff_dir ? {sin_bit, sreg[WIDTH-1:1]}
                             : {sreg[WIDTH-2:0], sin_bit};
  assign accept    = sin_valid && !flush;
  assign complete  = accept && (bit_cnt == CNT_LAST);
  assign slot_free = (slot_q == EMPTY) || dout_ready;
  assign load      = complete && slot_free;
  assign ovr_set   = complete && !slot_free;

  // Bit collector; bit_cnt wraps to 0 naturally on the completing bit
  // because WIDTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg    <= '0;
      bit_cnt <= '0;
      dir_q   <= 1'b0;
    end else if (flush) begin
      bit_cnt <= '0;
    end else if (sin_valid) begin
      sreg    <= shifted;
      bit_cnt <= bit_cnt + CNT_ONE;
      if (bit_cnt == '0) dir_q <= dir;
    end
  end

  // Output slot: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot_q <= EMPTY;
    else       slot_q <= slot_d;
  end

  // Output slot: next state
  always_comb begin
    slot_d = slot_q;
    unique case (slot_q)
      EMPTY: if (load) slot_d = FULL;
      FULL:  if (!load && dout_ready) slot_d = EMPTY;
      default: slot_d = EMPTY;
    endcase
  end

  // Output slot: outputs
  always_comb begin
    dout_valid = (slot_q == FULL);
    busy       = (bit_cnt != '0);
  end

  // Output data and sticky overrun flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      if (load) dout <= shifted;
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sin_valid;
  logic       sin_bit;
  logic       dir;
  logic       flush;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       overrun;
  logic       clr_ovr;
  logic [2:0] bit_cnt;
  logic       busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  sipo_deserializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .sin_valid  (sin_valid),
    .sin_bit    (sin_bit),
    .dir        (dir),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr),
    .bit_cnt    (bit_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin_valid = 1'b1;
    sin_bit   = b;
    step();
    sin_valid = 1'b0;
  endtask

  // MSB-first sends w[7] first; LSB-first sends w[0] first.
  task automatic send_word(input logic [7:0] w, input logic d,
                           input logic rdy_last, input logic clr_last);
    logic [7:0] v;
    v   = w;
    dir = d;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        dout_ready = rdy_last;
        clr_ovr    = clr_last;
      end
      send_bit(d ? v[i] : v[7-i]);
    end
    dout_ready = 1'b0;
    clr_ovr    = 1'b0;
  endtask

  task automatic drain();
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
  endtask

  initial begin
    logic [7:0] seq;
    reset = 1'b1; sin_valid = 1'b0; sin_bit = 1'b0; dir = 1'b0;
    flush = 1'b0; dout_ready = 1'b0; clr_ovr = 1'b0;
    #12;
    check("rst_dout",    32'(dout),       32'h0);
    check("rst_valid",   32'(dout_valid), 32'h0);
    check("rst_overrun", 32'(overrun),    32'h0);
    check("rst_bit_cnt", 32'(bit_cnt),    32'h0);
    check("rst_busy",    32'(busy),       32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // 1: MSB-first 0,0,0,1,1,1,0,1 -> 0x1D
    seq = 8'b0001_1101;
    dir = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(seq[7-i]);
    check("t1_cnt7",   32'(bit_cnt),    32'h7);
    check("t1_busy7",  32'(busy),       32'h1);
    check("t1_valid7", 32'(dout_valid), 32'h0);
    send_bit(seq[0]);
    check("t1_dout",  32'(dout),       32'h1D);
    check("t1_valid", 32'(dout_valid), 32'h1);
    check("t1_cnt",   32'(bit_cnt),    32'h0);
    check("t1_busy",  32'(busy),       32'h0);
    drain();
    check("t1_drain_valid", 32'(dout_valid), 32'h0);
    check("t1_drain_dout",  32'(dout),       32'h1D);

    // 2: LSB-first, same bit order, gap after bit 3, dir toggled mid-word -> 0xB8
    dir = 1'b1;
    send_bit(seq[7]);
    dir = 1'b0;
    send_bit(seq[6]);
    send_bit(seq[5]);
    step();
    step();
    check("t2_gap_cnt", 32'(bit_cnt), 32'h3);
    for (int i = 4; i >= 0; i--) begin
      dir = ~dir;
      send_bit(seq[i]);
    end
    check("t2_dout",  32'(dout),       32'hB8);
    check("t2_valid", 32'(dout_valid), 32'h1);
    drain();

    // 3: overrun, clear, and set winning over a simultaneous clear
    send_word(8'h1D, 1'b0, 1'b0, 1'b0);
    check("t3_first_ovr", 32'(overrun), 32'h0);
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    check("t3_dout",    32'(dout),       32'h1D);
    check("t3_valid",   32'(dout_valid), 32'h1);
    check("t3_overrun", 32'(overrun),    32'h1);
    pulse_clr();
    check("t3_clr", 32'(overrun), 32'h0);
    send_word(8'hFF, 1'b0, 1'b0, 1'b1);
    check("t3_set_wins", 32'(overrun), 32'h1);
    check("t3_dout2",    32'(dout),    32'h1D);
    pulse_clr();

    // 4: drain on the same cycle as completion
    check("t4_pre_valid", 32'(dout_valid), 32'h1);
    send_word(8'h3C, 1'b0, 1'b1, 1'b0);
    check("t4_dout",    32'(dout),       32'h3C);
    check("t4_valid",   32'(dout_valid), 32'h1);
    check("t4_overrun", 32'(overrun),    32'h0);
    drain();
    check("t4_drain_valid", 32'(dout_valid), 32'h0);

    // 5: flush wins over sin_valid and discards the partial word
    dir = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    flush = 1'b1;
    send_bit(1'b1);
    flush = 1'b0;
    check("t5_cnt",   32'(bit_cnt),    32'h0);
    check("t5_busy",  32'(busy),       32'h0);
    check("t5_valid", 32'(dout_valid), 32'h0);
    send_word(8'hC3, 1'b0, 1'b0, 1'b0);
    check("t5_dout", 32'(dout), 32'hC3);

    // 6: async reset mid-word with valid and overrun set
    send_word(8'h77, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("t6_pre_cnt",   32'(bit_cnt),    32'h5);
    check("t6_pre_valid", 32'(dout_valid), 32'h1);
    check("t6_pre_ovr",   32'(overrun),    32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_dout",    32'(dout),       32'h0);
    check("t6_valid",   32'(dout_valid), 32'h0);
    check("t6_overrun", 32'(overrun),    32'h0);
    check("t6_cnt",     32'(bit_cnt),    32'h0);
    check("t6_busy",    32'(busy),       32'h0);
    @(negedge clk);
    reset = 1'b0;
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    check("t6_after_dout",  32'(dout),       32'h5A);
    check("t6_after_valid", 32'(dout_valid), 32'h1);
    send_word(8'h5A, 1'b1, 1'b1, 1'b0);
    check("t6_lsb_dout", 32'(dout), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in, parallel-out word receiver: the receiving end of our shift-register serial links. It collects WIDTH bits, one per clock when sin_valid is high, either MSB-first or LSB-first. It presents each completed word on a single-entry output register with a valid/ready handshake. An overrun flag and a flush control cover back-pressure and resynchronisation.

Parameters:
WIDTH, 8, word length in bits (power of two, >= 2)
CNT_W, $clog2(WIDTH), bit counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
sin_valid  input  1  sin_bit is valid this cycle
sin_bit  input  1  serial data bit
dir  input  1  0 = MSB-first (shift left), 1 = LSB-first (shift right); sampled on first bit of each word
flush  input  1  synchronous discard of the partial word
dout  output  WIDTH  last completed word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout this cycle
overrun  output  1  sticky: a completed word was dropped
clr_ovr  input  1  synchronous clear of overrun
bit_cnt  output  CNT_W  bits collected in the current word
busy  output  1  bit_cnt != 0

Behaviour:
- Reset (async, any time, including mid-word) clears the following to 0: shift register, bit_cnt, latched dir, dout, dout_valid and overrun. busy is therefore 0.
- A bit is accepted on a rising edge with sin_valid=1 and flush=0. Cycles with sin_valid=0 change nothing in the collector.
- dir is latched when a bit is accepted with bit_cnt==0. Changes to dir mid-word are ignored until the next word starts.
- Shift rule, MSB-first: sreg <= {sreg[WIDTH-2:0], sin_bit}. The first bit received ends at dout[WIDTH-1].
- Shift rule, LSB-first: sreg <= {sin_bit, sreg[WIDTH-1:1]}. The first bit received ends at dout[0].
- bit_cnt increments per accepted bit. The bit accepted with bit_cnt==WIDTH-1 completes the word, and bit_cnt wraps to 0 on that edge.
- Completion: the assembled word, including the completing bit, is the "new word".
- Output slot is free if dout_valid==0, or if dout_ready==1 in the same cycle.
- Slot free on completion: dout <= new word and dout_valid=1 from the next cycle. Latency is 1 clock from the final bit's edge.
- Slot not free on completion: the new word is dropped, dout and dout_valid are unchanged, and overrun <= 1.
- dout_valid && dout_ready with no completion: dout_valid <= 0 and dout holds its value.
- Simultaneous drain and completion: the new word is loaded, dout_valid stays 1, and no overrun is raised.
- flush=1: bit_cnt <= 0 and any partial word is discarded; sin_valid in the same cycle is ignored (flush wins).
- flush does not affect dout, dout_valid or overrun.
- overrun is sticky. clr_ovr clears it. If clr_ovr and a new overrun event occur in the same cycle, the set wins (overrun stays 1).
- sreg contents after flush or completion are don't-care, because each word fully refills WIDTH bits.
- State summary: COLLECT (bit_cnt 0..WIDTH-1) × output slot {EMPTY, FULL}.
  - EMPTY -> FULL on completion.
  - FULL -> EMPTY on ready without completion.
  - FULL -> FULL on ready with completion, or on completion without ready (the latter is an overrun).

Test Plan:
1. MSB-first word: reset, dir=0, bits 0,0,0,1,1,1,0,1 on consecutive cycles, dout_ready=0. Required: dout=8'h1D, dout_valid=1 exactly one cycle after the 8th bit, bit_cnt returns to 0, busy=0.
2. LSB-first word with gaps: same bit order, dir=1, sin_valid low for 2 cycles between bits 3 and 4, and dir toggled mid-word. Required: dout=8'hB8, with dir changes ignored.
3. Overrun: send 8'h1D (MSB-first), keep dout_ready=0, then send 8'hA5. Required: dout stays 8'h1D and overrun=1. Pulse clr_ovr: overrun=0.
4. Simultaneous drain: dout_valid=1 with 8'h1D, assert dout_ready on the same cycle as the final bit of 8'h3C. Required: dout=8'h3C, dout_valid stays 1, overrun=0.
5. Flush: send 3 bits, assert flush together with sin_valid=1, then send a full 8'hC3. Required: bit_cnt=0 after the flush, dout=8'hC3, and the earlier bits have no effect.
6. Async reset mid-word: 5 bits in, with dout_valid=1 and overrun=1. Assert reset between clock edges. Required: all outputs go to 0 immediately, without waiting for a clock edge; after release, the next 8 bits produce a correct word.
